mem_port_arbiter: RTL and testbench

- Shares the single accelerator scratch-memory port between the per-state execution modules.
- Requester 0 is the parameter fetch (GET_PARAM), requester 1 the data fetch (GET_DATA), requester 2 the write-back (WRITE_BACK).
- Grants are round-robin and burst-locked, with a forced release after MAX_BURST beats so no requester can hold the port indefinitely.
- Returns read data to the owner of each accepted read, one cycle after acceptance.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-locked arbiter that shares one scratch-memory port between N_REQ requesters.
// A grant is released on a final beat, after MAX_BURST accepted beats, or when the owner drops req before a beat.
module mem_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic {
        ST_ARB,
        ST_BUSY
    } state_t;

    state_t             state_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [IDX_W-1:0]   g_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]   beat_cnt_reg;
    logic [N_REQ-1:0]   rvalid_reg;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    logic               busy;
    logic               accept;
    logic               hit_max;
    logic               release_grant;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   arb_sel;
    logic               arb_found;
    logic [IDX_W1-1:0]  arb_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
            assign ack[gi]       = accept && (g_reg == IDX_W'(gi));
        end
    endgenerate

    assign busy      = (state_reg == ST_BUSY);
    assign mem_en    = busy && req[g_reg];
    assign mem_we    = mem_en && we[g_reg];
    assign mem_addr  = addr_arr[g_reg];
    assign mem_wdata = wdata_arr[g_reg];
    assign accept    = mem_en && mem_ready;

    assign hit_max       = ((beat_cnt_reg + CNT_W'(1)) == CNT_W'(MAX_BURST));
    assign release_grant = busy && ((accept && (last[g_reg] || hit_max)) || !req[g_reg]);
    assign ptr_next      = (g_reg == IDX_W'(N_REQ - 1)) ? '0 : g_reg + IDX_W'(1);

    assign gnt    = gnt_reg;
    assign rvalid = rvalid_reg;
    assign rdata  = mem_rdata;

    // Scan offsets from the far end down so the requester nearest rr_ptr is the last one written.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            arb_idx = {1'b0, rr_ptr_reg} + IDX_W1'(k);
            if (arb_idx >= IDX_W1'(N_REQ)) begin
                arb_idx = arb_idx - IDX_W1'(N_REQ);
            end
            if (req[arb_idx[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_ARB;
            gnt_reg      <= '0;
            g_reg        <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            rvalid_reg   <= '0;
        end else begin
            // The owner is captured here, so the return reaches it even after the grant drops.
            rvalid_reg <= '0;
            if (accept && !mem_we) begin
                rvalid_reg <= ONE_HOT0 << g_reg;
            end

            case (state_reg)
                ST_ARB: begin
                    if (arb_found) begin
                        state_reg    <= ST_BUSY;
                        gnt_reg      <= ONE_HOT0 << arb_sel;
                        g_reg        <= arb_sel;
                        beat_cnt_reg <= '0;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                    if (release_grant) begin
                        state_reg  <= ST_ARB;
                        gnt_reg    <= '0;
                        rr_ptr_reg <= ptr_next;
                    end
                end
                default: begin
                    state_reg <= ST_ARB;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_BURST=4): one cycle per cyc() call, outputs checked mid-cycle.
module tb_mem_port_arbiter;

    localparam int N_REQ     = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         we;
    logic [N_REQ-1:0]         last;
    logic [N_REQ*ADDR_W-1:0]  addr;
    logic [N_REQ*DATA_W-1:0]  wdata;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         ack;
    logic [N_REQ-1:0]         rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ready;
    logic [DATA_W-1:0]        mem_rdata;

    int checks;
    int failures;

    mem_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .last(last), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs for that cycle, then advance past the rising edge.
    task automatic cyc(input string tag, input logic r, input logic [2:0] rq, input logic [2:0] w,
                       input logic [2:0] l, input logic rdy,
                       input logic [2:0] e_gnt, input logic [2:0] e_ack, input logic [2:0] e_rv);
        rst = r; req = rq; we = w; last = l; mem_ready = rdy;
        #1;
        chk({tag, ".gnt"},    64'(gnt),    64'(e_gnt));
        chk({tag, ".ack"},    64'(ack),    64'(e_ack));
        chk({tag, ".mem_en"}, 64'(mem_en), 64'(|(e_gnt & rq)));
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(e_rv));
        $display("cyc %-10s rst=%0b req=%b last=%b rdy=%0b gnt=%b ack=%b rvalid=%b",
                 tag, r, rq, l, rdy, gnt, ack, rvalid);
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; req = '0; we = '0; last = '0; addr = '0; wdata = '0;
        mem_ready = 1'b1; mem_rdata = '0;
        @(posedge clk); #2;
        @(posedge clk); #2;

        // Reset state
        cyc("rst",     1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Single read by requester 1
        addr[1*ADDR_W +: ADDR_W] = 16'h0040;
        cyc("rd.c0",   0, 3'b010, 3'b000, 3'b010, 1, 3'b000, 3'b000, 3'b000);
        #0;
        rst = 0;
        req = 3'b010; last = 3'b010; we = 3'b000;
        #1;
        chk("rd.addr", 64'(mem_addr), 64'h0040);
        chk("rd.we",   64'(mem_we),   64'h0);
        #0;
        cyc("rd.c1",   0, 3'b010, 3'b000, 3'b010, 1, 3'b010, 3'b010, 3'b000);
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd.rdata", 64'(rdata), 64'hDEADBEEF);
        cyc("rd.c2",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b010);
        cyc("rd.c3",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Contention from reset: 2-beat write bursts, order 0,1,2,0 with one idle cycle between grants
        cyc("ct.rst",  1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ct.c0",   0, 3'b111, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ct.c1",   0, 3'b111, 3'b111, 3'b000, 1, 3'b001, 3'b001, 3'b000);
        cyc("ct.c2",   0, 3'b111, 3'b111, 3'b001, 1, 3'b001, 3'b001, 3'b000);
        cyc("ct.c3",   0, 3'b111, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ct.c4",   0, 3'b111, 3'b111, 3'b000, 1, 3'b010, 3'b010, 3'b000);
        cyc("ct.c5",   0, 3'b111, 3'b111, 3'b010, 1, 3'b010, 3'b010, 3'b000);
        cyc("ct.c6",   0, 3'b111, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ct.c7",   0, 3'b111, 3'b111, 3'b000, 1, 3'b100, 3'b100, 3'b000);
        cyc("ct.c8",   0, 3'b111, 3'b111, 3'b100, 1, 3'b100, 3'b100, 3'b000);
        cyc("ct.c9",   0, 3'b111, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        // requester 0 regains the port, then aborts by dropping req
        cyc("ct.c10",  0, 3'b000, 3'b111, 3'b000, 1, 3'b001, 3'b000, 3'b000);
        cyc("ct.c11",  0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Forced release after 4 beats; rr_ptr is 1 so requester 2 wins over 0
        cyc("fr.c0",   0, 3'b101, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("fr.c1",   0, 3'b101, 3'b111, 3'b000, 1, 3'b100, 3'b100, 3'b000);
        cyc("fr.c2",   0, 3'b101, 3'b111, 3'b000, 1, 3'b100, 3'b100, 3'b000);
        cyc("fr.c3",   0, 3'b101, 3'b111, 3'b000, 1, 3'b100, 3'b100, 3'b000);
        cyc("fr.c4",   0, 3'b101, 3'b111, 3'b000, 1, 3'b100, 3'b100, 3'b000);
        cyc("fr.c5",   0, 3'b101, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("fr.c6",   0, 3'b101, 3'b111, 3'b001, 1, 3'b001, 3'b001, 3'b000);
        cyc("fr.c7",   0, 3'b100, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("fr.c8",   0, 3'b000, 3'b111, 3'b000, 1, 3'b100, 3'b000, 3'b000);
        cyc("fr.c9",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Memory stall during a 3-beat write burst by requester 0 (rr_ptr is 0)
        cyc("st.c0",   0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        addr[0 +: ADDR_W] = 16'h0100; wdata[0 +: DATA_W] = 32'h0000_0011;
        cyc("st.c1",   0, 3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b001, 3'b000);
        addr[0 +: ADDR_W] = 16'h0101; wdata[0 +: DATA_W] = 32'h0000_0022;
        for (int s = 0; s < 3; s++) begin
            mem_ready = 1'b0;
            #1;
            chk("st.addr",  64'(mem_addr),  64'h0101);
            chk("st.wdata", 64'(mem_wdata), 64'h22);
            chk("st.we",    64'(mem_we),    64'h1);
            cyc("st.stall", 0, 3'b001, 3'b001, 3'b000, 0, 3'b001, 3'b000, 3'b000);
        end
        cyc("st.c5",   0, 3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b001, 3'b000);
        addr[0 +: ADDR_W] = 16'h0102; wdata[0 +: DATA_W] = 32'h0000_0033;
        cyc("st.c6",   0, 3'b001, 3'b001, 3'b001, 1, 3'b001, 3'b001, 3'b000);
        cyc("st.c7",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Abort: requester 1 drops req before any beat; next simultaneous request goes to 2
        cyc("ab.c0",   0, 3'b010, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ab.c1",   0, 3'b000, 3'b000, 3'b000, 1, 3'b010, 3'b000, 3'b000);
        cyc("ab.c2",   0, 3'b111, 3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("ab.c3",   0, 3'b111, 3'b111, 3'b100, 1, 3'b100, 3'b100, 3'b000);
        cyc("ab.c4",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);

        // Reset hits while a read by requester 1 is being accepted: the return is dropped
        cyc("rr.c0",   0, 3'b010, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("rr.c1",   1, 3'b010, 3'b000, 3'b000, 1, 3'b010, 3'b010, 3'b000);
        cyc("rr.c2",   0, 3'b110, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000);
        cyc("rr.c3",   0, 3'b110, 3'b000, 3'b010, 1, 3'b010, 3'b010, 3'b000);
        cyc("rr.c4",   0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
